fft_result_unloader: RTL and testbench
======================================

Name: fft_result_unloader

Overview:
Downstream consumer of fft_radix2_top. It captures one 16-bin parallel result frame when the FFT asserts valid, then streams the bins out one per beat over a valid/ready handshake. Each beat carries the bin index, re, im and an |re|+|im| magnitude estimate. At end of frame it reports the peak-magnitude bin, for LED or UART display logic on the board top level.

Parameters:
WIDTH, 16, bit width of each signed real/imag component
NPOINT, 16, bins per frame
IDX_W, 4, bin index width (log2 NPOINT)

Ports:
clk  in  1  system clock
rst_n  in  1  reset, asynchronous, active-low
frame_valid  in  1  one-cycle pulse from the FFT valid output; frame_real/imag are valid in that cycle
frame_real  in  WIDTH*NPOINT  packed signed real parts; bin k at [k*WIDTH +: WIDTH]
frame_imag  in  WIDTH*NPOINT  packed signed imaginary parts, same packing
out_valid  out  1  beat available
out_ready  in  1  sink accepts beat
out_index  out  IDX_W  bin index of the current beat
out_real  out  WIDTH  signed real part
out_imag  out  WIDTH  signed imaginary part
out_mag  out  WIDTH+1  unsigned |re|+|im|
out_last  out  1  high on the beat with index NPOINT-1
peak_valid  out  1  one-cycle pulse at end of frame
peak_index  out  IDX_W  bin with the largest out_mag; holds value until the next frame
peak_mag  out  WIDTH+1  magnitude of that bin; holds value until the next frame
busy  out  1  high whenever state is not IDLE
overrun  out  1  sticky; set when a frame_valid is dropped
overrun_clr  in  1  synchronous clear of overrun

Behaviour:
- Reset: async, all state and outputs go to 0; state = IDLE. Any shadow frame is discarded.
- FSM states: IDLE, STREAM, DONE.
- IDLE with frame_valid=1:
  - latch frame_real/frame_imag into shadow registers; idx=0; run_max=0; run_idx=0
  - go to STREAM
- STREAM:
  - out_valid=1; out_* are driven from shadow[idx]
  - Transfer occurs on out_valid && out_ready.
  - Without a transfer, all out_* hold stable.
  - On each transfer, if out_mag > run_max (strictly greater), update run_max/run_idx. Ties keep the lowest index.
  - A transfer with idx < NPOINT-1 increments idx.
  - A transfer with idx = NPOINT-1 (out_last=1) moves to DONE.
  - The peak compare includes the last beat.
- DONE (one cycle):
  - out_valid=0, peak_valid=1
  - peak_index/peak_mag load from run_idx/run_max, with the last-beat update already applied
  - go to IDLE
- Latency: frame_valid in cycle N gives the beat 0 offer in N+1. With out_ready held at 1, beats occupy N+1..N+16, peak_valid is high in N+17, and the block returns to IDLE in N+18.
- Magnitude: abs() of each component is taken as an unsigned WIDTH-bit value, so -32768 maps to 32768. The sum is WIDTH+1 bits, with no saturation and no overflow.
- frame_valid while state is not IDLE (STREAM or DONE): the frame is ignored, the shadow registers are untouched, and overrun is set to 1.
- overrun_clr and a new overrun event in the same cycle: set wins.
- out_last = out_valid && (idx == NPOINT-1).
- Reset asserted mid-STREAM:
  - out_valid drops immediately (asynchronously)
  - no peak_valid is produced
  - peak_index/peak_mag return to 0

Decomposition:
- Shared package fft_pkg holds:
  - NPOINT, WIDTH and IDX_W constants
  - the state enum (IDLE/STREAM/DONE)
  - the packed-bin slice helper, shared with fft_radix2_top and the board top
- One sub-module, fft_abs_sum: combinational signed |a|+|b| to a WIDTH+1-bit result. It is instantiated once, on the muxed shadow bin.

Test Plan:
- All bins re=100, im=0, out_ready=1, frame_valid at cycle N:
  - 16 beats on consecutive cycles N+1..N+16, index 0..15, mag 100 each
  - out_last only on index 15
  - peak_valid at N+17 with peak_index=0 (tie rule), peak_mag=100
- Bin 5 re=-300 im=400, all other bins 0: beat 5 mag=700; peak_index=5, peak_mag=700.
- out_ready driven 1,0,0,1 repeating:
  - out_* stable across stalled cycles
  - all 16 indices delivered exactly once, in order
  - peak_valid one cycle after the index-15 transfer
- Second frame_valid during STREAM at beat 3:
  - overrun=1; first frame's data continues unchanged
  - overrun_clr=1 then returns overrun to 0
- Bin 9 re=-32768 im=-32768: out_mag=65536 (17'h10000), peak_index=9.
- rst_n pulsed low after the beat-7 transfer:
  - out_valid=0, busy=0, and every other output 0 immediately
  - no peak_valid
  - a new frame_valid afterwards restarts at index 0

Source files
------------

// File: rtl/fft_pkg.sv
// Shared FFT constants, unloader state encoding and the packed-bin slice helper
// used by fft_radix2_top, fft_result_unloader and the board top level.
package fft_pkg;

    localparam int NPOINT = 16;
    localparam int WIDTH  = 16;
    localparam int IDX_W  = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DONE   = 2'd2
    } state_t;

    // Bin k of a frame packed as {bin NPOINT-1, ..., bin 1, bin 0}
    function automatic logic signed [WIDTH-1:0] bin_slice(
        input logic [WIDTH*NPOINT-1:0] frame,
        input logic [IDX_W-1:0]        k
    );
        return frame[k*WIDTH +: WIDTH];
    endfunction

endpackage

// File: rtl/fft_abs_sum.sv
// Combinational |a| + |b| magnitude estimate; the sum carries one extra bit so
// that even two most-negative inputs cannot overflow.
module fft_abs_sum #(
    parameter int WIDTH = fft_pkg::WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH:0]   sum
);

    // Two's-complement negate read back as unsigned: the most negative value maps to 2^(WIDTH-1)
    function automatic logic [WIDTH-1:0] abs_u(input logic signed [WIDTH-1:0] x);
        return x[WIDTH-1] ? (~x + 1'b1) : x;
    endfunction

    logic signed [WIDTH-1:0] a_s;
    logic signed [WIDTH-1:0] b_s;

    assign a_s = a;
    assign b_s = b;
    assign sum = {1'b0, abs_u(a_s)} + {1'b0, abs_u(b_s)};

endmodule

// File: rtl/fft_result_unloader.sv
// Captures one parallel FFT result frame and streams it out bin by bin over
// valid/ready, tracking the peak |re|+|im| bin and reporting it at end of frame.
module fft_result_unloader
    import fft_pkg::*;
#(
    parameter int WIDTH  = fft_pkg::WIDTH,
    parameter int NPOINT = fft_pkg::NPOINT,
    parameter int IDX_W  = fft_pkg::IDX_W
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    frame_valid,
    input  logic [WIDTH*NPOINT-1:0] frame_real,
    input  logic [WIDTH*NPOINT-1:0] frame_imag,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [IDX_W-1:0]        out_index,
    output logic [WIDTH-1:0]        out_real,
    output logic [WIDTH-1:0]        out_imag,
    output logic [WIDTH:0]          out_mag,
    output logic                    out_last,
    output logic                    peak_valid,
    output logic [IDX_W-1:0]        peak_index,
    output logic [WIDTH:0]          peak_mag,
    output logic                    busy,
    output logic                    overrun,
    input  logic                    overrun_clr
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NPOINT - 1);

    state_t                  state;
    logic [IDX_W-1:0]        idx;
    logic [WIDTH*NPOINT-1:0] shadow_re;
    logic [WIDTH*NPOINT-1:0] shadow_im;
    logic [WIDTH:0]          run_max;
    logic [IDX_W-1:0]        run_idx;

    logic signed [WIDTH-1:0] bin_re;
    logic signed [WIDTH-1:0] bin_im;
    logic [WIDTH:0]          bin_mag;
    logic                    xfer;
    logic                    new_peak;
    logic [WIDTH:0]          nxt_max;
    logic [IDX_W-1:0]        nxt_idx;

    assign bin_re = bin_slice(shadow_re, idx);
    assign bin_im = bin_slice(shadow_im, idx);

    fft_abs_sum #(.WIDTH(WIDTH)) u_abs_sum (
        .a   (bin_re),
        .b   (bin_im),
        .sum (bin_mag)
    );

    assign out_valid = (state == STREAM);
    assign out_last  = out_valid && (idx == LAST_IDX);
    assign out_index = idx;
    assign out_real  = bin_re;
    assign out_imag  = bin_im;
    assign out_mag   = bin_mag;
    assign busy      = (state != IDLE);
    assign xfer      = out_valid && out_ready;

    // Strict compare so that ties keep the lowest index
    assign new_peak = bin_mag > run_max;
    assign nxt_max  = new_peak ? bin_mag : run_max;
    assign nxt_idx  = new_peak ? idx : run_idx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            idx        <= '0;
            shadow_re  <= '0;
            shadow_im  <= '0;
            run_max    <= '0;
            run_idx    <= '0;
            peak_valid <= 1'b0;
            peak_index <= '0;
            peak_mag   <= '0;
            overrun    <= 1'b0;
        end else begin
            peak_valid <= 1'b0;

            if (frame_valid && (state != IDLE)) begin
                overrun <= 1'b1;
            end else if (overrun_clr) begin
                overrun <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (frame_valid) begin
                        shadow_re <= frame_real;
                        shadow_im <= frame_imag;
                        idx       <= '0;
                        run_max   <= '0;
                        run_idx   <= '0;
                        state     <= STREAM;
                    end
                end
                STREAM: begin
                    if (xfer) begin
                        run_max <= nxt_max;
                        run_idx <= nxt_idx;
                        // Peak registers load on the last transfer so they are valid during DONE
                        if (out_last) begin
                            peak_valid <= 1'b1;
                            peak_index <= nxt_idx;
                            peak_mag   <= nxt_max;
                            state      <= DONE;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fft_result_unloader.sv
// Directed bench for fft_result_unloader: streams hand-built frames through the
// unloader and compares every beat and the reported peak against expected values.
module tb_fft_result_unloader;

    localparam int W = 16;
    localparam int N = 16;

    logic            clk;
    logic            rst_n;
    logic            frame_valid;
    logic [W*N-1:0]  frame_real;
    logic [W*N-1:0]  frame_imag;
    logic            out_valid;
    logic            out_ready;
    logic [3:0]      out_index;
    logic [W-1:0]    out_real;
    logic [W-1:0]    out_imag;
    logic [W:0]      out_mag;
    logic            out_last;
    logic            peak_valid;
    logic [3:0]      peak_index;
    logic [W:0]      peak_mag;
    logic            busy;
    logic            overrun;
    logic            overrun_clr;

    int n_vec = 0;
    int n_err = 0;

    logic signed [W-1:0] re_m [N];
    logic signed [W-1:0] im_m [N];

    fft_result_unloader dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .frame_valid (frame_valid),
        .frame_real  (frame_real),
        .frame_imag  (frame_imag),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_index   (out_index),
        .out_real    (out_real),
        .out_imag    (out_imag),
        .out_mag     (out_mag),
        .out_last    (out_last),
        .peak_valid  (peak_valid),
        .peak_index  (peak_index),
        .peak_mag    (peak_mag),
        .busy        (busy),
        .overrun     (overrun),
        .overrun_clr (overrun_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    function automatic logic [31:0] model_mag(input int k);
        int a;
        int b;
        a = re_m[k];
        b = im_m[k];
        if (a < 0) a = -a;
        if (b < 0) b = -b;
        return 32'(a + b);
    endfunction

    task automatic load_frame();
        for (int k = 0; k < N; k++) begin
            frame_real[k*W +: W] = re_m[k];
            frame_imag[k*W +: W] = im_m[k];
        end
    endtask

    task automatic clear_model();
        for (int k = 0; k < N; k++) begin
            re_m[k] = '0;
            im_m[k] = '0;
        end
    endtask

    // Ends one cycle after the frame_valid edge, with beat 0 on offer
    task automatic start_frame();
        @(posedge clk); #1;
        load_frame();
        frame_valid = 1'b1;
        @(posedge clk); #1;
        frame_valid = 1'b0;
    endtask

    // mode 0: out_ready always 1; mode 1: out_ready 1,0,0,1 repeating
    task automatic consume(input int mode, input bit inject, input int pk_idx, input int pk_mag,
                           input string name);
        int exp_idx = 0;
        int cyc = 0;
        bit stalled = 0;
        logic [3:0]   p_idx;
        logic [W-1:0] p_re;
        logic [W-1:0] p_im;
        logic [W:0]   p_mag;
        while (exp_idx < N && cyc < 100) begin
            out_ready   = (mode == 0) ? 1'b1 : ((cyc % 4 == 0) || (cyc % 4 == 3));
            frame_valid = inject && (exp_idx == 3 || exp_idx == 6);
            overrun_clr = inject && (exp_idx == 6);
            if (inject && exp_idx == 3) check_val({name, ".ovr_pre"}, 32'(overrun), 32'd0);
            if (inject && (exp_idx == 4 || exp_idx == 7))
                check_val({name, ".ovr_set"}, 32'(overrun), 32'd1);
            #1;
            check_val({name, ".valid"}, 32'(out_valid), 32'd1);
            check_val({name, ".pk_quiet"}, 32'(peak_valid), 32'd0);
            if (stalled) begin
                check_val({name, ".hold_idx"}, 32'(out_index), 32'(p_idx));
                check_val({name, ".hold_re"}, 32'(out_real), 32'(p_re));
                check_val({name, ".hold_im"}, 32'(out_imag), 32'(p_im));
                check_val({name, ".hold_mag"}, 32'(out_mag), 32'(p_mag));
            end
            if (out_ready) begin
                check_val({name, ".idx"}, 32'(out_index), 32'(exp_idx));
                check_val({name, ".re"}, 32'(out_real), {16'h0, re_m[exp_idx]});
                check_val({name, ".im"}, 32'(out_imag), {16'h0, im_m[exp_idx]});
                check_val({name, ".mag"}, 32'(out_mag), model_mag(exp_idx));
                check_val({name, ".last"}, 32'(out_last), 32'(exp_idx == N - 1));
                exp_idx++;
                stalled = 0;
            end else begin
                stalled = 1;
            end
            p_idx = out_index;
            p_re  = out_real;
            p_im  = out_imag;
            p_mag = out_mag;
            @(posedge clk); #1;
            cyc++;
        end
        frame_valid = 1'b0;
        overrun_clr = 1'b0;
        out_ready   = 1'b1;
        check_val({name, ".beats"}, 32'(exp_idx), 32'(N));
        check_val({name, ".pk_valid"}, 32'(peak_valid), 32'd1);
        check_val({name, ".pk_idx"}, 32'(peak_index), 32'(pk_idx));
        check_val({name, ".pk_mag"}, 32'(peak_mag), 32'(pk_mag));
        check_val({name, ".done_valid"}, 32'(out_valid), 32'd0);
        check_val({name, ".done_busy"}, 32'(busy), 32'd1);
        @(posedge clk); #1;
        check_val({name, ".pk_pulse"}, 32'(peak_valid), 32'd0);
        check_val({name, ".idle_busy"}, 32'(busy), 32'd0);
        check_val({name, ".pk_hold"}, 32'(peak_index), 32'(pk_idx));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst_n       = 1'b0;
        frame_valid = 1'b0;
        frame_real  = '0;
        frame_imag  = '0;
        out_ready   = 1'b1;
        overrun_clr = 1'b0;
        #1;
        check_val("rst.valid", 32'(out_valid), 32'd0);
        check_val("rst.busy", 32'(busy), 32'd0);
        check_val("rst.pk_valid", 32'(peak_valid), 32'd0);
        check_val("rst.pk_idx", 32'(peak_index), 32'd0);
        check_val("rst.pk_mag", 32'(peak_mag), 32'd0);
        check_val("rst.overrun", 32'(overrun), 32'd0);
        check_val("rst.mag", 32'(out_mag), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Flat frame: every bin ties, lowest index wins
        for (int k = 0; k < N; k++) begin
            re_m[k] = 16'sd100;
            im_m[k] = '0;
        end
        start_frame();
        consume(0, 0, 0, 100, "flat");

        // Single tone in bin 5
        clear_model();
        re_m[5] = -16'sd300;
        im_m[5] = 16'sd400;
        start_frame();
        consume(0, 0, 5, 700, "bin5");

        // Ramp under back-pressure
        for (int k = 0; k < N; k++) begin
            re_m[k] = 16'(k * 10);
            im_m[k] = 16'(-k);
        end
        start_frame();
        consume(1, 0, 15, 165, "stall");

        // Extra frame_valid pulses mid-stream carry different data that must be ignored
        for (int k = 0; k < N; k++) begin
            re_m[k] = 16'(k);
            im_m[k] = '0;
        end
        re_m[11] = 16'sd1000;
        start_frame();
        for (int k = 0; k < N; k++) begin
            frame_real[k*W +: W] = 16'sd5000;
            frame_imag[k*W +: W] = 16'sd5000;
        end
        consume(0, 1, 11, 1000, "ovr");
        check_val("ovr.sticky", 32'(overrun), 32'd1);
        overrun_clr = 1'b1;
        @(posedge clk); #1;
        overrun_clr = 1'b0;
        check_val("ovr.clr", 32'(overrun), 32'd0);

        // Most negative components in bin 9
        clear_model();
        re_m[9] = 16'h8000;
        im_m[9] = 16'h8000;
        start_frame();
        consume(0, 0, 9, 65536, "minneg");

        // Reset mid-stream after the beat-7 transfer
        start_frame();
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
        end
        check_val("mrst.pre_idx", 32'(out_index), 32'd8);
        rst_n = 1'b0;
        #1;
        check_val("mrst.valid", 32'(out_valid), 32'd0);
        check_val("mrst.busy", 32'(busy), 32'd0);
        check_val("mrst.index", 32'(out_index), 32'd0);
        check_val("mrst.re", 32'(out_real), 32'd0);
        check_val("mrst.im", 32'(out_imag), 32'd0);
        check_val("mrst.mag", 32'(out_mag), 32'd0);
        check_val("mrst.last", 32'(out_last), 32'd0);
        check_val("mrst.pk_valid", 32'(peak_valid), 32'd0);
        check_val("mrst.pk_idx", 32'(peak_index), 32'd0);
        check_val("mrst.pk_mag", 32'(peak_mag), 32'd0);
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            check_val("mrst.pk_hold0", 32'(peak_valid), 32'd0);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        check_val("mrst.after_pk", 32'(peak_valid), 32'd0);
        check_val("mrst.after_busy", 32'(busy), 32'd0);

        for (int k = 0; k < N; k++) begin
            re_m[k] = 16'sd100;
            im_m[k] = '0;
        end
        start_frame();
        consume(0, 0, 0, 100, "restart");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
